// File: rtl/pipe_codec_pkg.sv
// Shared constants, types and reference encoder for the pipelined stream codec.
package pipe_codec_pkg;

    localparam int WIDTH = 8;
    localparam int SKIP  = 3;
    localparam int INV3  = 171;

    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } state_t;

    // e[n] from x[n-3], x[n-4], x[n-5], x[n-6]
    function automatic logic [WIDTH-1:0] enc_model(
        input logic [WIDTH-1:0] x0,
        input logic [WIDTH-1:0] x1,
        input logic [WIDTH-1:0] x2,
        input logic [WIDTH-1:0] x3
    );
        logic [WIDTH+3:0] s;
        s = 3 * {4'b0, x0} + {4'b0, x1} + 4 * {4'b0, x2} + {4'b0, x3};
        return WIDTH'(s);
    endfunction

endpackage

// File: rtl/pipe_inv_core.sv
// Combinational inverse of the stream encoder: x = INV3 * (e - h1 - 4*h2 - h3).
module pipe_inv_core
    import pipe_codec_pkg::*;
#(
    parameter int W = pipe_codec_pkg::WIDTH
) (
    input  logic [W-1:0] i_e,
    input  logic [W-1:0] i_h1,
    input  logic [W-1:0] i_h2,
    input  logic [W-1:0] i_h3,
    output logic [W-1:0] o_x
);

    logic [W+1:0] w_t;
    logic [W+1:0] w_p;

    assign w_t = {2'b00, i_e} - {2'b00, i_h1}
               - {i_h2, 2'b00} - {2'b00, i_h3};
    assign w_p = {2'b00, W'(w_t)} * (W + 2)'(INV3);
    assign o_x = W'(w_p);

endmodule

// File: rtl/pipe_stream_decoder.sv
// Stream decoder: warm-up alignment FSM, history registers, registered outputs.
module pipe_stream_decoder
    import pipe_codec_pkg::*;
#(
    parameter int WIDTH = pipe_codec_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enc_valid,
    input  logic [WIDTH-1:0] enc_data,
    input  logic             resync,
    output logic             dec_valid,
    output logic [WIDTH-1:0] dec_data,
    output logic             synced,
    output logic             sync_err
);

    localparam int CW = $clog2(SKIP + 1);

    if (WIDTH != 8) begin : g_width_chk
        $error("pipe_stream_decoder: only WIDTH=8 is supported");
    end

    state_t           r_state, w_state_nx, w_state_b;
    logic [CW-1:0]    r_cnt, w_cnt_nx, w_cnt_b;
    logic             r_err, w_err_nx, w_err_b;
    logic [WIDTH-1:0] r_h1, r_h2, r_h3;
    logic [WIDTH-1:0] w_h1_nx, w_h2_nx, w_h3_nx;
    logic             r_dv, w_dv_nx;
    logic [WIDTH-1:0] r_dd, w_dd_nx;
    logic [WIDTH-1:0] w_x;

    pipe_inv_core #(.W(WIDTH)) u_core (
        .i_e  (enc_data),
        .i_h1 (r_h1),
        .i_h2 (r_h2),
        .i_h3 (r_h3),
        .o_x  (w_x)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= WARMUP;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_h1    <= '0;
            r_h2    <= '0;
            r_h3    <= '0;
            r_dv    <= 1'b0;
            r_dd    <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_err   <= w_err_nx;
            r_h1    <= w_h1_nx;
            r_h2    <= w_h2_nx;
            r_h3    <= w_h3_nx;
            r_dv    <= w_dv_nx;
            r_dd    <= w_dd_nx;
        end
    end

    always_comb begin
        // resync first rewinds to a clean warm-up, then the sample applies
        w_state_b  = resync ? WARMUP : r_state;
        w_cnt_b    = resync ? '0 : r_cnt;
        w_err_b    = resync ? 1'b0 : r_err;
        w_state_nx = w_state_b;
        w_cnt_nx   = w_cnt_b;
        w_err_nx   = w_err_b;
        w_h1_nx    = resync ? '0 : r_h1;
        w_h2_nx    = resync ? '0 : r_h2;
        w_h3_nx    = resync ? '0 : r_h3;
        w_dv_nx    = 1'b0;
        w_dd_nx    = r_dd;
        if (enc_valid) begin
            unique case (w_state_b)
                WARMUP: begin
                    w_err_nx = w_err_b | (enc_data != '0);
                    if (w_cnt_b == CW'(SKIP - 1)) begin
                        w_state_nx = RUN;
                    end else begin
                        w_cnt_nx = w_cnt_b + 1'b1;
                    end
                end
                RUN: begin
                    w_dv_nx = 1'b1;
                    w_dd_nx = w_x;
                    w_h1_nx = w_x;
                    w_h2_nx = r_h1;
                    w_h3_nx = r_h2;
                end
                default: ;
            endcase
        end
    end

    assign dec_valid = r_dv;
    assign dec_data  = r_dd;
    assign synced    = (r_state == RUN);
    assign sync_err  = r_err;

endmodule
